// File: rtl/regfile_write_arbiter.sv
// Single write-port arbiter for the 32x32 register file: fixed priority to port A
// with starvation relief for port B. Define REGFILE_WARB_INIT_EN for the x1..x31 clear after reset.
module regfile_write_arbiter #(
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_regWrite,
  output logic [ADDR_W-1:0] rf_waddress,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done,
  output logic              busy
);

  localparam int unsigned      CNT_W = 4;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             run_c;
  logic             b_pri_c;

`ifdef REGFILE_WARB_INIT_EN
  typedef enum logic {INIT, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_done_q, init_done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= INIT;
      clr_cnt_q   <= ADDR_W'(1);
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Walk clr_cnt over x1..x(NUM_REGS-1), then hand the port to the requesters.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      INIT: begin
        if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end else begin
          clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
      end
      RUN:     state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  assign run_c     = !rst && (state_q == RUN);
  assign init_done = init_done_q;
`else
  assign run_c     = !rst;
  assign init_done = !rst;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end

  // Grant, write-port mux and starvation tracking; the register file captures on the handshake edge.
  always_comb begin
    a_ready     = 1'b0;
    b_ready     = 1'b0;
    rf_regWrite = 1'b0;
    rf_waddress = '0;
    rf_wdata    = '0;
    starve_d    = starve_q;
    b_pri_c     = (starve_q == LIMIT);
    if (run_c) begin
      a_ready = a_valid && !(b_pri_c && b_valid);
      b_ready = b_valid && (!a_valid || b_pri_c);
      if (a_ready) begin
        rf_regWrite = (a_addr != '0);
        rf_waddress = a_addr;
        rf_wdata    = a_data;
      end else if (b_ready) begin
        rf_regWrite = (b_addr != '0);
        rf_waddress = b_addr;
        rf_wdata    = b_data;
      end
      if (b_valid && !b_ready) starve_d = b_pri_c ? starve_q : starve_q + CNT_W'(1);
      else                     starve_d = '0;
    end
`ifdef REGFILE_WARB_INIT_EN
    else if (!rst && (state_q == INIT)) begin
      rf_regWrite = 1'b1;
      rf_waddress = clr_cnt_q;
    end
`endif
  end

  assign busy = rf_regWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-free priority model plus register-file image,
// checked every negedge, with literal vectors pinning key cycles.
module tb_regfile_write_arbiter;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned NREG  = 32;
  localparam int          LIMIT = 4;
`ifdef REGFILE_WARB_INIT_EN
  localparam int          INIT_CYC = 31;
`else
  localparam int          INIT_CYC = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, rf_regWrite, init_done, busy;
  logic [AW-1:0] rf_waddress;
  logic [DW-1:0] rf_wdata;

  regfile_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NREG), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rf_regWrite(rf_regWrite), .rf_waddress(rf_waddress), .rf_wdata(rf_wdata),
    .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // literal expectation for the current cycle, set by the stimulus
  logic          lit_en = 1'b0, lit_chk_wd;
  logic          lit_ar, lit_br, lit_we, lit_busy, lit_done;
  logic [AW-1:0] lit_wa;
  logic [DW-1:0] lit_wd;
  int            lit_starve;
  logic          do_final = 1'b0;

  // model state
  int            m_starve;
  int            m_init_left;
  logic [DW-1:0] exp_rf [NREG];
  logic [DW-1:0] mir_rf [NREG];
  logic          rf_inited = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : compare
    int            gnt;  // 0 none, 1 A, 2 B
    logic          e_ar, e_br, e_we, e_done;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    if (!rf_inited) begin
      for (int r = 0; r < NREG; r++) begin exp_rf[r] = '0; mir_rf[r] = '0; end
      rf_inited = 1'b1;
    end
    if (rst) begin
      chk("rst_a_ready", 32'(a_ready), 0);
      chk("rst_b_ready", 32'(b_ready), 0);
      chk("rst_regWrite", 32'(rf_regWrite), 0);
      chk("rst_waddress", 32'(rf_waddress), 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_busy", 32'(busy), 0);
      m_starve    = 0;
      m_init_left = INIT_CYC;
    end else begin
      gnt = 0; e_ar = 0; e_br = 0; e_we = 0; e_wa = '0; e_wd = '0; e_done = 0;
      if (m_init_left > 0) begin
        e_we = 1;
        e_wa = AW'(NREG - m_init_left);
      end else begin
        e_done = 1;
        if (b_valid && (m_starve == LIMIT || !a_valid)) gnt = 2;
        else if (a_valid)                              gnt = 1;
        if (gnt == 1) begin e_ar = 1; e_wa = a_addr; e_wd = a_data; end
        if (gnt == 2) begin e_br = 1; e_wa = b_addr; e_wd = b_data; end
        e_we = (gnt != 0) && (e_wa != 0);
      end
      chk("a_ready", 32'(a_ready), 32'(e_ar));
      chk("b_ready", 32'(b_ready), 32'(e_br));
      chk("regWrite", 32'(rf_regWrite), 32'(e_we));
      chk("busy", 32'(busy), 32'(e_we));
      chk("init_done", 32'(init_done), 32'(e_done));
      chk("waddress", 32'(rf_waddress), 32'(e_wa));
      if (e_we || gnt == 0) chk("wdata", rf_wdata, e_wd);
      // advance the model to the state after the coming edge
      if (m_init_left > 0) begin
        exp_rf[e_wa] = '0;
        m_init_left--;
      end else begin
        if (e_we) exp_rf[e_wa] = e_wd;
        if (b_valid && gnt != 2) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        else                     m_starve = 0;
      end
      if (rf_regWrite) mir_rf[rf_waddress] = rf_wdata;
      if (lit_en) begin
        chk("lit_a_ready", 32'(a_ready), 32'(lit_ar));
        chk("lit_b_ready", 32'(b_ready), 32'(lit_br));
        chk("lit_regWrite", 32'(rf_regWrite), 32'(lit_we));
        chk("lit_busy", 32'(busy), 32'(lit_busy));
        chk("lit_init_done", 32'(init_done), 32'(lit_done));
        chk("lit_waddress", 32'(rf_waddress), 32'(lit_wa));
        if (lit_chk_wd) chk("lit_wdata", rf_wdata, lit_wd);
        chk("lit_starve_model", 32'(m_starve), 32'(lit_starve));
      end
      if (do_final)
        for (int r = 1; r < NREG; r++) chk($sformatf("rf_x%0d", r), mir_rf[r], exp_rf[r]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    lit_en   = 1'b0;
    do_final = 1'b0;
  endtask

  task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
  endtask

  task automatic lit(input logic ar, input logic br, input logic we, input logic [AW-1:0] wa,
                     input logic chkwd, input logic [DW-1:0] wd, input logic dn, input int st);
    lit_en = 1'b1; lit_ar = ar; lit_br = br; lit_we = we; lit_busy = we; lit_wa = wa;
    lit_chk_wd = chkwd; lit_wd = wd; lit_done = dn; lit_starve = st;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, '0, '0, 0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
`ifdef REGFILE_WARB_INIT_EN
    lit(0, 0, 1, AW'(1), 1, '0, 0, 0);
    repeat (10) step();
    #1 rst = 1'b1;                       // mid-INIT, between edges
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    lit(0, 0, 1, AW'(1), 1, '0, 0, 0);   // clear restarts at x1
    repeat (31) step();
    lit(0, 0, 0, '0, 1, '0, 1, 0);       // first RUN cycle
    step();
`else
    lit(0, 0, 0, '0, 1, '0, 1, 0);       // RUN straight out of reset, idle
    step();
`endif
    // both ports: A wins, then B gets through after LIMIT denials
    drive(1, AW'(5), 32'hDEADBEEF, 1, AW'(6), 32'h00001234);
    lit(1, 0, 1, AW'(5), 1, 32'hDEADBEEF, 1, 1);
    step(); drive(1, AW'(7), 32'h11111111, 1, AW'(6), 32'h00001234);
    step(); drive(1, AW'(8), 32'h22222222, 1, AW'(6), 32'h00001234);
    step(); drive(1, AW'(9), 32'h33333333, 1, AW'(6), 32'h00001234);
    lit(1, 0, 1, AW'(9), 1, 32'h33333333, 1, 4);
    step(); drive(1, AW'(10), 32'h44444444, 1, AW'(6), 32'h00001234);
    lit(0, 1, 1, AW'(6), 1, 32'h00001234, 1, 0);
    step(); drive(1, AW'(10), 32'h44444444, 1, AW'(12), 32'h00005555);
    lit(1, 0, 1, AW'(10), 1, 32'h44444444, 1, 1);
    step(); drive(1, AW'(11), 32'h66666666, 0, '0, '0);  // B withdraws: counter clears
    lit(1, 0, 1, AW'(11), 1, 32'h66666666, 1, 0);
    step(); drive(0, '0, '0, 0, '0, '0);
    // write to x0: accepted, no write
    step(); drive(1, AW'(0), 32'hFFFFFFFF, 0, '0, '0);
    lit(1, 0, 0, AW'(0), 0, '0, 1, 0);
    // B alone to x31
    step(); drive(0, '0, '0, 1, AW'(31), 32'hA5A5A5A5);
    lit(0, 1, 1, AW'(31), 1, 32'hA5A5A5A5, 1, 0);
    // same address from both ports: B's later write wins
    step(); drive(1, AW'(3), 32'hAAAA0001, 1, AW'(3), 32'hBBBB0002);
    step(); drive(0, '0, '0, 1, AW'(3), 32'hBBBB0002);
    lit(0, 1, 1, AW'(3), 1, 32'hBBBB0002, 1, 0);
    step(); drive(0, '0, '0, 0, '0, '0);
    // a few mixed patterns
    for (int i = 0; i < 12; i++) begin
      step();
      drive(1'(i % 3 != 2), AW'(i + 13), 32'hC0DE0000 + 32'(i), 1'(i % 2), AW'(i + 1), 32'hB0000000 + 32'(i));
    end
    // reset in RUN with a request pending, which is dropped
    step(); drive(1, AW'(4), 32'hCAFEF00D, 0, '0, '0);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (INIT_CYC + 2) step();
    drive(0, '0, '0, 0, '0, '0);
    step();
    do_final = 1'b1;
    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
